// File: rtl/cpumc_pkg.sv
// Shared decode definitions for the banked CPU memory controller.
// Latency: combinational helpers only.
// Backpressure: none. CPUMC_SRAM_EN maps 0x6000-0x7FFF to work SRAM.
package cpumc_pkg;

    typedef enum logic [2:0] {
        RGN_RAM,
        RGN_SRAM,
        RGN_PRG_SW,
        RGN_PRG_FIX,
        RGN_INVALID
    } region_e;

    localparam logic [15:0] RAM_BASE      = 16'h0000;
    localparam logic [15:0] RAM_LIMIT     = 16'h1FFF;
    localparam logic [15:0] SRAM_BASE     = 16'h6000;
    localparam logic [15:0] SRAM_LIMIT    = 16'h7FFF;
    localparam logic [15:0] PRG_SW_BASE   = 16'h8000;
    localparam logic [15:0] PRG_SW_LIMIT  = 16'hBFFF;
    localparam logic [15:0] PRG_FIX_BASE  = 16'hC000;
    localparam logic [15:0] PRG_FIX_LIMIT = 16'hFFFF;

    // Offset-from-base compare; wraps below the base so one test covers both bounds.
    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] base,
                                      input logic [15:0] limit);
        logic [15:0] off;
        off = a - base;
        return off <= (limit - base);
    endfunction

    function automatic region_e cpumc_decode(input logic [15:0] a);
        region_e r;
        r = RGN_INVALID;
        if (in_range(a, RAM_BASE, RAM_LIMIT))
            r = RGN_RAM;
        else if (in_range(a, PRG_SW_BASE, PRG_SW_LIMIT))
            r = RGN_PRG_SW;
        else if (in_range(a, PRG_FIX_BASE, PRG_FIX_LIMIT))
            r = RGN_PRG_FIX;
`ifdef CPUMC_SRAM_EN
        else if (in_range(a, SRAM_BASE, SRAM_LIMIT))
            r = RGN_SRAM;
`endif
        return r;
    endfunction

endpackage

// File: rtl/cpumc_prg_store.sv
// PRG-ROM backing store: BANK_CNT banks of 16 KB each.
// Latency: one edge for read data.
// Backpressure: none.
module cpumc_prg_store #(
    parameter int BANK_CNT = 8
) (
    input  logic                            clk_i,
    input  logic                            we_i,
    input  logic [$clog2(BANK_CNT)+13:0]    addr_i,
    input  logic [7:0]                      din_i,
    output logic [7:0]                      dout_o
);

    single_port_ram_sync #(
        .ADDR_WIDTH($clog2(BANK_CNT) + 14),
        .DATA_WIDTH(8)
    ) u_mem (
        .clk_i (clk_i),
        .we_i  (we_i),
        .addr_i(addr_i),
        .din_i (din_i),
        .dout_o(dout_o)
    );

endmodule

// File: rtl/single_port_ram_sync.sv
// Single-port synchronous RAM, read-before-write.
// Latency: read data registered, valid one edge after the address.
// Backpressure: none; accepts an access every cycle.
module single_port_ram_sync #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1<<ADDR_WIDTH)-1];

    // Write on enable, always register the old contents at the address.
    always_ff @(posedge clk_i) begin
        if (we_i)
            mem_q[addr_i] <= din_i;
        dout_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/cpumc_banked.sv
// Banked CPU memory controller: RAM mirror, switchable + fixed PRG bank (SRAM with CPUMC_SRAM_EN).
// Latency: ack one cycle after the accepting edge; at most one access per two cycles.
// Backpressure: req is only sampled in IDLE; requests during ACCESS are ignored.
module cpumc_banked
    import cpumc_pkg::*;
#(
    parameter int         PRG_BANK_CNT   = 8,
    parameter int         RAM_ADDR_WIDTH = 11,
    parameter logic [7:0] INVALID_DATA   = 8'hCD
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req,
    input  logic                            wr,
    input  logic [15:0]                     addr,
    input  logic [7:0]                      din,
    input  logic                            load_mode,
    output logic [7:0]                      dout,
    output logic                            ack,
    output logic                            invalid_req,
    output logic [$clog2(PRG_BANK_CNT)-1:0] prg_bank
);

    localparam int BANK_W = $clog2(PRG_BANK_CNT);
    localparam int PRG_AW = BANK_W + 14;

    typedef enum logic {S_IDLE, S_ACCESS} state_e;

    state_e             state_q, state_d;
    logic               wr_q, wr_d, lm_q, lm_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         din_q, din_d;
    logic               ack_q, ack_d, inv_q, inv_d;
    logic [7:0]         dout_q, dout_d;
    logic [BANK_W-1:0]  bank_q, bank_d;

    logic               in_access;
    logic [15:0]        cur_addr;
    region_e            cur_rgn;
    logic [BANK_W-1:0]  bank_sel;
    logic [PRG_AW-1:0]  prg_addr;
    logic               ram_we, prg_we;
    logic [7:0]         ram_rdata, prg_rdata;

    // Live address in IDLE so the synchronous read completes on the accepting edge;
    // captured address in ACCESS so the write lands where the request pointed.
    always_comb begin
        in_access = (state_q == S_ACCESS);
        cur_addr  = in_access ? addr_q : addr;
        cur_rgn   = cpumc_decode(cur_addr);
        bank_sel  = (cur_rgn == RGN_PRG_FIX) ? BANK_W'(PRG_BANK_CNT - 1) : bank_q;
        prg_addr  = {bank_sel, cur_addr[13:0]};
        ram_we    = in_access && wr_q && (cur_rgn == RGN_RAM);
        prg_we    = in_access && wr_q && lm_q &&
                    ((cur_rgn == RGN_PRG_SW) || (cur_rgn == RGN_PRG_FIX));
    end

    single_port_ram_sync #(
        .ADDR_WIDTH(RAM_ADDR_WIDTH),
        .DATA_WIDTH(8)
    ) u_ram (
        .clk_i (clk),
        .we_i  (ram_we),
        .addr_i(cur_addr[RAM_ADDR_WIDTH-1:0]),
        .din_i (din_q),
        .dout_o(ram_rdata)
    );

    cpumc_prg_store #(
        .BANK_CNT(PRG_BANK_CNT)
    ) u_prg (
        .clk_i (clk),
        .we_i  (prg_we),
        .addr_i(prg_addr),
        .din_i (din_q),
        .dout_o(prg_rdata)
    );

`ifdef CPUMC_SRAM_EN
    logic       sram_we;
    logic [7:0] sram_rdata;

    assign sram_we = in_access && wr_q && (cur_rgn == RGN_SRAM);

    single_port_ram_sync #(
        .ADDR_WIDTH(13),
        .DATA_WIDTH(8)
    ) u_sram (
        .clk_i (clk),
        .we_i  (sram_we),
        .addr_i(cur_addr[12:0]),
        .din_i (din_q),
        .dout_o(sram_rdata)
    );
`endif

    // Next state: capture in IDLE, complete and respond in ACCESS.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        lm_d    = lm_q;
        addr_d  = addr_q;
        din_d   = din_q;
        ack_d   = 1'b0;
        dout_d  = dout_q;
        inv_d   = inv_q;
        bank_d  = bank_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    lm_d    = load_mode;
                    addr_d  = addr;
                    din_d   = din;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                state_d = S_IDLE;
                ack_d   = 1'b1;
                inv_d   = 1'b0;
                case (cur_rgn)
                    RGN_RAM: begin
                        if (!wr_q)
                            dout_d = ram_rdata;
                    end
`ifdef CPUMC_SRAM_EN
                    RGN_SRAM: begin
                        if (!wr_q)
                            dout_d = sram_rdata;
                    end
`endif
                    RGN_PRG_SW, RGN_PRG_FIX: begin
                        if (!wr_q)
                            dout_d = prg_rdata;
                        else if (!lm_q)
                            bank_d = din_q[BANK_W-1:0];
                    end
                    default: begin
                        dout_d = INVALID_DATA;
                        inv_d  = 1'b1;
                    end
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and response registers; reset aborts any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            lm_q    <= 1'b0;
            addr_q  <= 16'h0000;
            din_q   <= 8'h00;
            ack_q   <= 1'b0;
            dout_q  <= 8'h00;
            inv_q   <= 1'b0;
            bank_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            lm_q    <= lm_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ack_q   <= ack_d;
            dout_q  <= dout_d;
            inv_q   <= inv_d;
            bank_q  <= bank_d;
        end
    end

    assign dout        = dout_q;
    assign ack         = ack_q;
    assign invalid_req = inv_q;
    assign prg_bank    = bank_q;

endmodule

// File: tb/tb_cpumc_banked.sv
// Self-checking bench for cpumc_banked with a region/array reference model.
// Latency: checks ack one cycle after acceptance and the two-cycle request rate.
// Backpressure: checks that requests held through ACCESS are only taken in IDLE.
module tb_cpumc_banked;

    localparam int         NB    = 8;
    localparam int         RAMSZ = 2048;
    localparam logic [7:0] INV   = 8'hCD;
`ifdef CPUMC_SRAM_EN
    localparam bit SRAM_EN = 1'b1;
`else
    localparam bit SRAM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic        load_mode = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  din = 8'h00;
    logic [7:0]  dout;
    logic        ack;
    logic        invalid_req;
    logic [2:0]  prg_bank;

    int total = 0;
    int bad   = 0;

    // Reference state: byte arrays per region, current bank, last returned data.
    logic [7:0] ram_m  [int];
    logic [7:0] prg_m  [int];
    logic [7:0] sram_m [int];
    int         bank_m = 0;
    logic [7:0] last_dout = 8'h00;
    bit         last_known = 1'b1;

    cpumc_banked #(
        .PRG_BANK_CNT  (NB),
        .RAM_ADDR_WIDTH(11),
        .INVALID_DATA  (INV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .wr         (wr),
        .addr       (addr),
        .din        (din),
        .load_mode  (load_mode),
        .dout       (dout),
        .ack        (ack),
        .invalid_req(invalid_req),
        .prg_bank   (prg_bank)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory-map rules applied to the model; returns the expected response.
    task automatic model(input logic w, input logic [15:0] a, input logic [7:0] d,
                         input logic lm, output logic [7:0] e_dout,
                         output logic e_inv, output bit e_known);
        int idx;
        int bank;
        e_dout  = last_dout;
        e_inv   = 1'b0;
        e_known = last_known;
        if (a < 16'h2000) begin
            idx = int'(a) % RAMSZ;
            if (w) ram_m[idx] = d;
            else if (ram_m.exists(idx)) begin e_dout = ram_m[idx]; e_known = 1'b1; end
            else e_known = 1'b0;
        end else if (a >= 16'h8000) begin
            bank = (a >= 16'hC000) ? NB - 1 : bank_m;
            idx  = bank * 16384 + int'(a) % 16384;
            if (w) begin
                if (lm) prg_m[idx] = d;
                else    bank_m = int'(d) % NB;
            end else if (prg_m.exists(idx)) begin e_dout = prg_m[idx]; e_known = 1'b1; end
            else e_known = 1'b0;
        end else if (SRAM_EN && a >= 16'h6000) begin
            idx = int'(a) % 8192;
            if (w) sram_m[idx] = d;
            else if (sram_m.exists(idx)) begin e_dout = sram_m[idx]; e_known = 1'b1; end
            else e_known = 1'b0;
        end else begin
            e_dout  = INV;
            e_inv   = 1'b1;
            e_known = 1'b1;
        end
        last_dout  = e_dout;
        last_known = e_known;
    endtask

    // One full request: drive, check ack latency, check response against model.
    task automatic do_access(input logic w, input logic [15:0] a, input logic [7:0] d,
                             input logic lm, output logic [7:0] obs);
        logic [7:0] e_dout;
        logic       e_inv;
        bit         e_known;
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; din = d; load_mode = lm;
        @(posedge clk); #1;
        req = 1'b0; wr = 1'($urandom); addr = 16'($urandom); din = 8'($urandom);
        check("ack_early", 32'(ack), 32'd0);
        @(posedge clk); #1;
        model(w, a, d, lm, e_dout, e_inv, e_known);
        check("ack", 32'(ack), 32'd1);
        check("invalid_req", 32'(invalid_req), 32'(e_inv));
        if (e_known) check("dout", 32'(dout), 32'(e_dout));
        check("prg_bank", 32'(prg_bank), 32'(bank_m));
        obs = dout;
    endtask

    initial begin
        logic [7:0]  obs;
        logic [15:0] ra;
        logic [7:0]  rd;
        logic        rw, rlm;
        int          k;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_inv", 32'(invalid_req), 32'd0);
        check("rst_bank", 32'(prg_bank), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // RAM mirroring
        do_access(1'b1, 16'h0123, 8'h5A, 1'b0, obs);
        do_access(1'b0, 16'h0923, 8'h00, 1'b0, obs);
        check("ram_mirror", 32'(obs), 32'h5A);

        // Bank register vs ROM load
        do_access(1'b1, 16'h8000, 8'h11, 1'b1, obs);
        do_access(1'b1, 16'h8000, 8'h03, 1'b0, obs);
        check("bank_set3", 32'(prg_bank), 32'd3);
        do_access(1'b1, 16'h8000, 8'h33, 1'b1, obs);
        do_access(1'b1, 16'h8000, 8'h00, 1'b0, obs);
        do_access(1'b1, 16'h8000, 8'h03, 1'b0, obs);
        do_access(1'b0, 16'h8000, 8'h00, 1'b0, obs);
        check("bank_seq", 32'(obs), 32'h33);

        // Fixed last bank ignores the bank register
        do_access(1'b1, 16'hFFFC, 8'hEE, 1'b1, obs);
        for (int b = 0; b < NB; b++) begin
            do_access(1'b1, 16'h8000, 8'(b), 1'b0, obs);
            do_access(1'b0, 16'hFFFC, 8'h00, 1'b0, obs);
            check("fixed_bank", 32'(obs), 32'hEE);
        end

        // Unmapped and optional SRAM window
        do_access(1'b0, 16'h4016, 8'h00, 1'b0, obs);
        check("unmapped_dout", 32'(obs), 32'hCD);
        check("unmapped_inv", 32'(invalid_req), 32'd1);
        do_access(1'b1, 16'h6000, 8'h77, 1'b0, obs);
        do_access(1'b0, 16'h6000, 8'h00, 1'b0, obs);
        check("sram_dout", 32'(obs), SRAM_EN ? 32'h77 : 32'hCD);
        check("sram_inv", 32'(invalid_req), SRAM_EN ? 32'd0 : 32'd1);

        // req held through ACCESS: one ack per two cycles, capture only in IDLE
        do_access(1'b1, 16'h0010, 8'h21, 1'b0, obs);
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = 16'h0123;
        @(posedge clk); #1;
        check("hold_ack0", 32'(ack), 32'd0);
        @(negedge clk);
        addr = 16'h0010;
        @(posedge clk); #1;
        check("hold_ack1", 32'(ack), 32'd1);
        check("hold_dout1", 32'(dout), 32'h5A);
        @(posedge clk); #1;
        check("hold_ack2", 32'(ack), 32'd0);
        @(posedge clk); #1;
        check("hold_ack3", 32'(ack), 32'd1);
        check("hold_dout3", 32'(dout), 32'h21);
        @(posedge clk); #1;
        check("hold_ack4", 32'(ack), 32'd0);
        @(posedge clk); #1;
        check("hold_ack5", 32'(ack), 32'd1);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk); #1;
        check("hold_ack6", 32'(ack), 32'd0);
        @(posedge clk); #1;
        check("hold_ack7", 32'(ack), 32'd0);
        last_dout = 8'h21;
        last_known = 1'b1;

        // Reset during ACCESS aborts the write
        do_access(1'b1, 16'h8000, 8'h05, 1'b0, obs);
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 16'h0010; din = 8'hAA;
        @(posedge clk); #1;
        req = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_ack_now", 32'(ack), 32'd0);
        @(posedge clk); #1;
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_bank", 32'(prg_bank), 32'd0);
        check("abort_dout", 32'(dout), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        bank_m = 0;
        last_dout = 8'h00;
        last_known = 1'b1;
        do_access(1'b0, 16'h0010, 8'h00, 1'b0, obs);
        check("abort_mem", 32'(obs), 32'h21);

        // Randomized mix over all regions
        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 4);
            case (k)
                0:       ra = {3'b000, 2'($urandom), 11'($urandom_range(0, 15))};
                1:       ra = 16'h8000 + 16'($urandom_range(0, 15));
                2:       ra = 16'hFFF0 + 16'($urandom_range(0, 15));
                3:       ra = 16'($urandom_range(16'h2000, 16'h5FFF));
                default: ra = 16'h6000 + 16'($urandom_range(0, 15));
            endcase
            rw  = 1'($urandom_range(0, 1));
            rlm = 1'($urandom_range(0, 1));
            rd  = 8'($urandom);
            do_access(rw, ra, rd, rlm, obs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
